// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with a zero-latency (Mealy) grant, one turnaround cycle
// per hand-over and a hold counter that preempts owners after MAX_HOLD cycles.
module rr_grant_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               preempt
);
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t            state, state_nx;
  logic [ID_W-1:0]   ptr, ptr_nx, owner, owner_nx, owner_inc;
  logic [CNT_W-1:0]  hold_cnt, cnt_nx;
  logic [ID_W-1:0]   win_id, gid;
  logic              win_vld, gnt_en, pre;

  // Rotating scan from ptr; the first requester found wins, 0 if none.
  always_comb begin
    int idx;
    win_vld = 1'b0;
    win_id  = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(idx);
      end
    end
  end

  assign owner_inc = (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    owner_nx = owner;
    cnt_nx   = hold_cnt;
    gnt_en   = 1'b0;
    gid      = '0;
    pre      = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          gnt_en   = 1'b1;
          gid      = win_id;
          state_nx = OWNED;
          owner_nx = win_id;
          cnt_nx   = CNT_W'(1);
        end
      end
      OWNED: begin
        // Release and preempt share the hand-over path; only the flag differs.
        if (!req[owner] || hold_cnt == CNT_W'(MAX_HOLD)) begin
          pre      = req[owner];
          state_nx = IDLE;
          ptr_nx   = owner_inc;
          cnt_nx   = '0;
        end else begin
          gnt_en = 1'b1;
          gid    = owner;
          cnt_nx = hold_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (reset) begin
      gnt_en = 1'b0;
      gid    = '0;
      pre    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      owner    <= owner_nx;
      hold_cnt <= cnt_nx;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign grant[i] = gnt_en && (gid == ID_W'(i));
  end

  assign grant_id = gid;
  assign busy     = (state == OWNED);
  assign preempt  = pre;
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench: vector table on a MAX_HOLD=8 instance, hand-written
// preempt / sole-requester sequences on a MAX_HOLD=4 instance.
module tb_rr_grant_arbiter;
  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] req8, req4;
  logic [3:0] grant8, grant4;
  logic [1:0] gid8, gid4;
  logic       busy8, busy4, pre8, pre4;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  rr_grant_arbiter #(.NUM_REQ(4), .MAX_HOLD(8)) dut8 (
    .clock(clock), .reset(reset), .req(req8), .grant(grant8),
    .grant_id(gid8), .busy(busy8), .preempt(pre8));

  rr_grant_arbiter #(.NUM_REQ(4), .MAX_HOLD(4)) dut4 (
    .clock(clock), .reset(reset), .req(req4), .grant(grant4),
    .grant_id(gid4), .busy(busy4), .preempt(pre4));

  typedef struct {
    logic       rst;
    logic [3:0] rq;
    logic [3:0] g;
    logic [1:0] id;
    logic       b;
    logic       p;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic rst, input logic [3:0] rq, input logic [3:0] g,
                     input logic [1:0] id, input logic b, input logic p);
    vec_t v;
    v.rst = rst; v.rq = rq; v.g = g; v.id = id; v.b = b; v.p = p;
    tv.push_back(v);
  endtask

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle: drive after the previous edge, compare on the falling edge.
  task automatic cyc(input bit use4, input logic r, input logic [3:0] rq,
                     input logic [3:0] eg, input logic [1:0] eid,
                     input logic eb, input logic ep, input string tag);
    reset = r;
    if (use4) begin req4 = rq; req8 = 4'b0; end
    else      begin req8 = rq; req4 = 4'b0; end
    @(negedge clock);
    if (use4) begin
      cmp({tag, ".grant"},    8'(grant4), 8'(eg));
      cmp({tag, ".grant_id"}, 8'(gid4),   8'(eid));
      cmp({tag, ".busy"},     8'(busy4),  8'(eb));
      cmp({tag, ".preempt"},  8'(pre4),   8'(ep));
    end else begin
      cmp({tag, ".grant"},    8'(grant8), 8'(eg));
      cmp({tag, ".grant_id"}, 8'(gid8),   8'(eid));
      cmp({tag, ".busy"},     8'(busy8),  8'(eb));
      cmp({tag, ".preempt"},  8'(pre8),   8'(ep));
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    // reset, idle, zero-latency win
    add(0, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b0101, 4'b0001, 0, 0, 0);
    add(0, 4'b0101, 4'b0001, 0, 1, 0);
    // rotation 0,1,2,3,0 with one gap cycle per hand-over
    add(0, 4'b1110, 4'b0000, 0, 1, 0);
    add(0, 4'b1111, 4'b0010, 1, 0, 0);
    add(0, 4'b1111, 4'b0010, 1, 1, 0);
    add(0, 4'b1101, 4'b0000, 0, 1, 0);
    add(0, 4'b1111, 4'b0100, 2, 0, 0);
    add(0, 4'b1111, 4'b0100, 2, 1, 0);
    add(0, 4'b1011, 4'b0000, 0, 1, 0);
    add(0, 4'b1111, 4'b1000, 3, 0, 0);
    add(0, 4'b1111, 4'b1000, 3, 1, 0);
    add(0, 4'b0111, 4'b0000, 0, 1, 0);
    add(0, 4'b1111, 4'b0001, 0, 0, 0);
    add(0, 4'b1111, 4'b0001, 0, 1, 0);
    add(0, 4'b1110, 4'b0000, 0, 1, 0);
    // owner 2 releases -> ptr=3; 0011 then wraps to 0
    add(0, 4'b0100, 4'b0100, 2, 0, 0);
    add(0, 4'b0100, 4'b0100, 2, 1, 0);
    add(0, 4'b0000, 4'b0000, 0, 1, 0);
    add(0, 4'b0011, 4'b0001, 0, 0, 0);
    // non-owner request ignored while owned
    add(0, 4'b0011, 4'b0001, 0, 1, 0);
    add(0, 4'b0010, 4'b0000, 0, 1, 0);
    add(0, 4'b0010, 4'b0010, 1, 0, 0);
    add(0, 4'b0000, 4'b0000, 0, 1, 0);
    // reset while owner 2 has hold_cnt=2
    add(0, 4'b1111, 4'b0100, 2, 0, 0);
    add(0, 4'b1111, 4'b0100, 2, 1, 0);
    add(1, 4'b1111, 4'b0000, 0, 1, 0);
    add(0, 4'b1111, 4'b0001, 0, 0, 0);
    add(0, 4'b1111, 4'b0001, 0, 1, 0);
    add(0, 4'b0000, 4'b0000, 0, 1, 0);
    add(0, 4'b0000, 4'b0000, 0, 0, 0);

    reset = 1'b1; req8 = 4'b0; req4 = 4'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    foreach (tv[i])
      cyc(0, tv[i].rst, tv[i].rq, tv[i].g, tv[i].id, tv[i].b, tv[i].p,
          $sformatf("vec%0d", i));

    // Preempt with two steady requesters, MAX_HOLD=4
    for (int k = 0; k < 11; k++) begin
      logic [3:0] eg; logic [1:0] eid; logic eb, ep;
      eg = 4'b0; eid = 2'd0; eb = 1'b1; ep = 1'b0;
      if (k < 4 || k == 10)    begin eg = 4'b0001; eid = 2'd0; eb = (k != 0 && k != 10); end
      else if (k == 4 || k == 9) ep = 1'b1;
      else                     begin eg = 4'b0010; eid = 2'd1; eb = (k != 5); end
      cyc(1, 0, 4'b0011, eg, eid, eb, ep, $sformatf("pre%0d", k));
    end
    cyc(1, 0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, "pre_rel");
    cyc(1, 0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "pre_idle");

    // Sole requester is preempted and re-wins after each gap
    for (int k = 0; k < 15; k++) begin
      int p;
      p = k % 5;
      if (p < 4) cyc(1, 0, 4'b1000, 4'b1000, 2'd3, (p != 0), 1'b0, $sformatf("sole%0d", k));
      else       cyc(1, 0, 4'b1000, 4'b0000, 2'd0, 1'b1,     1'b1, $sformatf("sole%0d", k));
    end
    cyc(1, 0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "sole_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
